// File: rtl/dbg_reg_responder_pkg.sv
// Shared definitions for the debug NoC configuration-register responder:
// flit/class encodings, header field layout and the responder FSM states.
package dbg_reg_responder_pkg;

  localparam int unsigned FLIT_W    = 18;
  localparam int unsigned CONTENT_W = 16;

  localparam logic [1:0] FLIT_PAYLOAD = 2'b00;
  localparam logic [1:0] FLIT_HEADER  = 2'b01;
  localparam logic [1:0] FLIT_LAST    = 2'b10;
  localparam logic [1:0] FLIT_SINGLE  = 2'b11;

  localparam logic [2:0] CLASS_READ_REQ  = 3'b000;
  localparam logic [2:0] CLASS_WRITE_REQ = 3'b001;
  localparam logic [2:0] CLASS_READ_RESP = 3'b010;

  localparam int unsigned HDR_DEST_LSB  = 11;
  localparam int unsigned HDR_DEST_W    = 5;
  localparam int unsigned HDR_CLASS_LSB = 8;
  localparam int unsigned HDR_CLASS_W   = 3;
  localparam int unsigned HDR_SRC_LSB   = 0;
  localparam int unsigned HDR_SRC_W     = 5;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_WDATA,
    ST_DRAIN,
    ST_RESP_HDR,
    ST_RESP_DATA
  } state_e;

  typedef struct packed {
    logic [1:0]           ftype;
    logic [CONTENT_W-1:0] content;
  } flit_t;

  // Header content: dest | class | reserved (0) | src
  function automatic logic [CONTENT_W-1:0] make_hdr(input logic [HDR_DEST_W-1:0]  dest,
                                                    input logic [HDR_CLASS_W-1:0] cls,
                                                    input logic [HDR_SRC_W-1:0]   src);
    return {dest, cls, 3'b000, src};
  endfunction

endpackage

// File: rtl/dbg_reg_responder_if.sv
// Debug NoC configuration-channel link: request flits toward the responder,
// response flits back toward the host, each with a valid/ready handshake.
interface dbg_reg_responder_if;
  import dbg_reg_responder_pkg::*;

  flit_t dbgnoc_in_flit;
  logic  dbgnoc_in_valid;
  logic  dbgnoc_in_ready;
  flit_t dbgnoc_out_flit;
  logic  dbgnoc_out_valid;
  logic  dbgnoc_out_ready;

  modport master (
    output dbgnoc_in_flit,
    output dbgnoc_in_valid,
    input  dbgnoc_in_ready,
    input  dbgnoc_out_flit,
    input  dbgnoc_out_valid,
    output dbgnoc_out_ready
  );

  modport slave (
    input  dbgnoc_in_flit,
    input  dbgnoc_in_valid,
    output dbgnoc_in_ready,
    output dbgnoc_out_flit,
    output dbgnoc_out_valid,
    input  dbgnoc_out_ready
  );

endinterface

// File: rtl/dbg_reg_file.sv
// Register file: two read-only ID registers (0,1) plus NUM_REGS-2 writable
// registers with a one-cycle write strobe each and a combinational read port.
module dbg_reg_file #(
  parameter logic [15:0] MODULE_TYPE    = 16'h0000,
  parameter logic [15:0] MODULE_VERSION = 16'h0000,
  parameter int unsigned NUM_REGS       = 8
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         wr_en,
  input  logic [15:0]                  wr_addr,
  input  logic [15:0]                  wr_data,
  input  logic [15:0]                  rd_addr,
  output logic [15:0]                  rd_data,
  output logic [16*(NUM_REGS-2)-1:0]   regs_flat,
  output logic [NUM_REGS-3:0]          wr_strobe
);

  localparam int unsigned NUM_RW = NUM_REGS - 2;

  logic [16*NUM_RW-1:0] regs_q, regs_d;
  logic [NUM_RW-1:0]    strobe_q, strobe_d;

  // Writes to the ID registers or past the end match no slot and vanish
  always_comb begin
    regs_d   = regs_q;
    strobe_d = '0;
    for (int unsigned i = 0; i < NUM_RW; i++) begin
      if (wr_en && (wr_addr == 16'(i + 2))) begin
        regs_d[i*16 +: 16] = wr_data;
        strobe_d[i]        = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      regs_q   <= '0;
      strobe_q <= '0;
    end else begin
      regs_q   <= regs_d;
      strobe_q <= strobe_d;
    end
  end

  always_comb begin
    rd_data = 16'h0000;
    if (rd_addr == 16'd0) begin
      rd_data = MODULE_TYPE;
    end else if (rd_addr == 16'd1) begin
      rd_data = MODULE_VERSION;
    end else begin
      for (int unsigned i = 0; i < NUM_RW; i++) begin
        if (rd_addr == 16'(i + 2)) rd_data = regs_q[i*16 +: 16];
      end
    end
  end

  assign regs_flat = regs_q;
  assign wr_strobe = strobe_q;

endmodule

// File: rtl/dbg_reg_responder.sv
// Debug NoC configuration-register responder: parses read/write request
// packets, drives the register file and returns read-response packets.
module dbg_reg_responder
  import dbg_reg_responder_pkg::*;
#(
  parameter logic [4:0]  MODULE_ID      = 5'd1,
  parameter logic [15:0] MODULE_TYPE    = 16'h0000,
  parameter logic [15:0] MODULE_VERSION = 16'h0000,
  parameter int unsigned NUM_REGS       = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  dbg_reg_responder_if.slave         noc,
  output logic [16*(NUM_REGS-2)-1:0] regs_flat,
  output logic [NUM_REGS-3:0]        reg_wr_strobe
);

  state_e                  state_q, state_d;
  logic                    in_ready_q, in_ready_d;
  logic                    out_valid_q, out_valid_d;
  flit_t                   out_flit_q, out_flit_d;
  logic                    is_write_q, is_write_d;
  logic [HDR_SRC_W-1:0]    req_src_q, req_src_d;
  logic [CONTENT_W-1:0]    rdata_q, rdata_d;
  logic                    wr_en_q, wr_en_d;
  logic [CONTENT_W-1:0]    wr_addr_q, wr_addr_d;
  logic [CONTENT_W-1:0]    wr_data_q, wr_data_d;

  flit_t                   in_flit_c;
  logic                    in_fire_c;
  logic                    out_fire_c;
  logic [HDR_CLASS_W-1:0]  in_class_c;
  logic [CONTENT_W-1:0]    rd_data_c;

  assign in_flit_c  = noc.dbgnoc_in_flit;
  assign in_fire_c  = noc.dbgnoc_in_valid && in_ready_q;
  assign out_fire_c = out_valid_q && noc.dbgnoc_out_ready;
  assign in_class_c = in_flit_c.content[HDR_CLASS_LSB +: HDR_CLASS_W];

  // Read port is addressed straight from the incoming flit so data is
  // captured on the same edge the address flit is accepted.
  dbg_reg_file #(
    .MODULE_TYPE    (MODULE_TYPE),
    .MODULE_VERSION (MODULE_VERSION),
    .NUM_REGS       (NUM_REGS)
  ) u_reg_file (
    .clk       (clk),
    .rst_n     (rst_n),
    .wr_en     (wr_en_q),
    .wr_addr   (wr_addr_q),
    .wr_data   (wr_data_q),
    .rd_addr   (in_flit_c.content),
    .rd_data   (rd_data_c),
    .regs_flat (regs_flat),
    .wr_strobe (reg_wr_strobe)
  );

  always_comb begin
    state_d     = state_q;
    out_valid_d = out_valid_q;
    out_flit_d  = out_flit_q;
    is_write_d  = is_write_q;
    req_src_d   = req_src_q;
    rdata_d     = rdata_q;
    wr_en_d     = 1'b0;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;

    unique case (state_q)
      ST_IDLE: begin
        if (in_fire_c && (in_flit_c.ftype == FLIT_HEADER)) begin
          req_src_d = in_flit_c.content[HDR_SRC_LSB +: HDR_SRC_W];
          if (in_class_c == CLASS_READ_REQ) begin
            is_write_d = 1'b0;
            state_d    = ST_ADDR;
          end else if (in_class_c == CLASS_WRITE_REQ) begin
            is_write_d = 1'b1;
            state_d    = ST_ADDR;
          end else begin
            state_d    = ST_DRAIN;
          end
        end
      end

      ST_ADDR: begin
        if (in_fire_c) begin
          unique case (in_flit_c.ftype)
            FLIT_LAST: begin
              if (!is_write_q) begin
                rdata_d             = rd_data_c;
                out_flit_d.ftype    = FLIT_HEADER;
                out_flit_d.content  = make_hdr(req_src_q, CLASS_READ_RESP, MODULE_ID);
                out_valid_d         = 1'b1;
                state_d             = ST_RESP_HDR;
              end else begin
                state_d = ST_IDLE;
              end
            end
            FLIT_PAYLOAD: begin
              if (is_write_q) begin
                wr_addr_d = in_flit_c.content;
                state_d   = ST_WDATA;
              end else begin
                state_d   = ST_DRAIN;
              end
            end
            default: state_d = ST_IDLE;
          endcase
        end
      end

      ST_WDATA: begin
        if (in_fire_c) begin
          unique case (in_flit_c.ftype)
            FLIT_LAST: begin
              wr_en_d   = 1'b1;
              wr_data_d = in_flit_c.content;
              state_d   = ST_IDLE;
            end
            FLIT_PAYLOAD: state_d = ST_DRAIN;
            default:      state_d = ST_IDLE;
          endcase
        end
      end

      ST_DRAIN: begin
        if (in_fire_c && (in_flit_c.ftype == FLIT_LAST)) state_d = ST_IDLE;
      end

      ST_RESP_HDR: begin
        if (out_fire_c) begin
          out_flit_d.ftype   = FLIT_LAST;
          out_flit_d.content = rdata_q;
          state_d            = ST_RESP_DATA;
        end
      end

      ST_RESP_DATA: begin
        if (out_fire_c) begin
          out_valid_d = 1'b0;
          out_flit_d  = '0;
          state_d     = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase

    // Registered decode of the next state keeps out_ready off the in_ready path
    in_ready_d = (state_d == ST_IDLE) || (state_d == ST_ADDR) ||
                 (state_d == ST_WDATA) || (state_d == ST_DRAIN);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_flit_q  <= '0;
      is_write_q  <= 1'b0;
      req_src_q   <= '0;
      rdata_q     <= '0;
      wr_en_q     <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
    end else begin
      state_q     <= state_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      out_flit_q  <= out_flit_d;
      is_write_q  <= is_write_d;
      req_src_q   <= req_src_d;
      rdata_q     <= rdata_d;
      wr_en_q     <= wr_en_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
    end
  end

  assign noc.dbgnoc_in_ready  = in_ready_q;
  assign noc.dbgnoc_out_valid = out_valid_q;
  assign noc.dbgnoc_out_flit  = out_flit_q;

endmodule

// File: tb/tb_dbg_reg_responder.sv
// Directed bench for dbg_reg_responder: expected response flits are queued
// as requests are issued and checked as the responder emits them.
module tb_dbg_reg_responder;
  import dbg_reg_responder_pkg::*;

  localparam int unsigned NREG = 8;
  localparam logic [4:0]  MID  = 5'd3;
  localparam logic [15:0] MTYP = 16'hbeef;
  localparam logic [15:0] MVER = 16'h0102;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [16*(NREG-2)-1:0] regs_flat;
  logic [NREG-3:0]        reg_wr_strobe;

  int n_cmp = 0;
  int n_err = 0;
  logic [17:0] exp_q[$];
  logic [17:0] exp_f;

  always #5 clk = ~clk;

  dbg_reg_responder_if noc ();

  dbg_reg_responder #(
    .MODULE_ID      (MID),
    .MODULE_TYPE    (MTYP),
    .MODULE_VERSION (MVER),
    .NUM_REGS       (NREG)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .noc           (noc.slave),
    .regs_flat     (regs_flat),
    .reg_wr_strobe (reg_wr_strobe)
  );

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Output monitor: every response flit handshake must match the queue head
  always @(negedge clk) begin
    if (noc.dbgnoc_out_valid === 1'b1 && noc.dbgnoc_out_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $error("FAIL unexpected_flit: observed %0h expected none", 18'(noc.dbgnoc_out_flit));
      end else begin
        exp_f = exp_q.pop_front();
        n_cmp++;
        assert (18'(noc.dbgnoc_out_flit) === exp_f) else begin
          n_err++;
          $error("FAIL resp_flit: observed %0h expected %0h", 18'(noc.dbgnoc_out_flit), exp_f);
        end
      end
    end
  end

  // Present one flit and hold it until accepted (bounded)
  task automatic send(input logic [1:0] t, input logic [15:0] c);
    bit done = 1'b0;
    noc.dbgnoc_in_flit  = {t, c};
    noc.dbgnoc_in_valid = 1'b1;
    for (int i = 0; i < 50 && !done; i++) begin
      @(negedge clk);
      if (noc.dbgnoc_in_ready === 1'b1) done = 1'b1;
      @(posedge clk);
      #1;
    end
    noc.dbgnoc_in_valid = 1'b0;
    if (!done) begin
      n_cmp++;
      n_err++;
      $error("FAIL send_timeout: observed no accept expected accept of %0h", {t, c});
    end
  endtask

  function automatic logic [15:0] req_hdr(input logic [2:0] cls, input logic [4:0] src);
    return {5'd1, cls, 3'b000, src};
  endfunction

  task automatic read_req(input logic [4:0] src, input logic [15:0] addr, input logic [15:0] data);
    exp_q.push_back({2'b01, src, 3'b010, 3'b000, MID});
    exp_q.push_back({2'b10, data});
    send(2'b01, req_hdr(3'b000, src));
    send(2'b10, addr);
  endtask

  task automatic write_req(input logic [15:0] addr, input logic [15:0] data);
    send(2'b01, req_hdr(3'b001, 5'd2));
    send(2'b00, addr);
    send(2'b10, data);
  endtask

  task automatic wait_drain(input string tag);
    for (int i = 0; i < 100 && exp_q.size() != 0; i++) begin
      @(posedge clk);
      #1;
    end
    chk(tag, 128'(exp_q.size()), 128'(0));
  endtask

  initial begin
    noc.dbgnoc_in_flit   = '0;
    noc.dbgnoc_in_valid  = 1'b0;
    noc.dbgnoc_out_ready = 1'b1;

    // Reset values
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", 128'(noc.dbgnoc_in_ready), 128'(0));
    chk("rst_out_valid", 128'(noc.dbgnoc_out_valid), 128'(0));
    chk("rst_out_flit", 128'(noc.dbgnoc_out_flit), 128'(0));
    chk("rst_regs", 128'(regs_flat), 128'(0));
    chk("rst_strobe", 128'(reg_wr_strobe), 128'(0));
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("post_rst_in_ready", 128'(noc.dbgnoc_in_ready), 128'(1));

    // Read MODULE_TYPE with latency checks
    read_req(5'd2, 16'h0000, MTYP);
    chk("hdr_latency_valid", 128'(noc.dbgnoc_out_valid), 128'(1));
    chk("hdr_flit", 128'(noc.dbgnoc_out_flit), 128'({2'b01, 16'h1203}));
    chk("hdr_in_ready", 128'(noc.dbgnoc_in_ready), 128'(0));
    @(posedge clk);
    #1;
    chk("data_flit", 128'(noc.dbgnoc_out_flit), 128'({2'b10, 16'hbeef}));
    @(posedge clk);
    #1;
    chk("done_out_valid", 128'(noc.dbgnoc_out_valid), 128'(0));
    chk("done_in_ready", 128'(noc.dbgnoc_in_ready), 128'(1));
    wait_drain("drain_type");

    read_req(5'd4, 16'h0001, MVER);
    wait_drain("drain_version");

    // Write reg 2, strobe timing, read back
    write_req(16'h0002, 16'h1234);
    chk("wr_strobe_before", 128'(reg_wr_strobe), 128'(0));
    @(posedge clk);
    #1;
    chk("wr_strobe_pulse", 128'(reg_wr_strobe), 128'(6'b000001));
    chk("wr_reg2", 128'(regs_flat[15:0]), 128'(16'h1234));
    @(posedge clk);
    #1;
    chk("wr_strobe_after", 128'(reg_wr_strobe), 128'(0));
    read_req(5'd2, 16'h0002, 16'h1234);
    wait_drain("drain_rb2");

    // Last writable register
    write_req(16'h0007, 16'habcd);
    @(posedge clk);
    #1;
    chk("wr_strobe_reg7", 128'(reg_wr_strobe), 128'(6'b100000));
    chk("wr_reg7", 128'(regs_flat[95:80]), 128'(16'habcd));
    chk("wr_reg2_kept", 128'(regs_flat[15:0]), 128'(16'h1234));

    // Backpressure during a read
    noc.dbgnoc_out_ready = 1'b0;
    read_req(5'd5, 16'h0007, 16'habcd);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_valid", 128'(noc.dbgnoc_out_valid), 128'(1));
      chk("bp_hdr", 128'(noc.dbgnoc_out_flit), 128'({2'b01, 5'd5, 3'b010, 3'b000, MID}));
      chk("bp_in_ready", 128'(noc.dbgnoc_in_ready), 128'(0));
    end
    @(posedge clk);
    #1;
    noc.dbgnoc_out_ready = 1'b1;
    wait_drain("drain_bp");

    // Out-of-range read
    read_req(5'd2, 16'h0009, 16'h0000);
    wait_drain("drain_oor");

    // Unknown class packet, stray SINGLE and orphan LAST: no response
    send(2'b01, req_hdr(3'b111, 5'd2));
    send(2'b00, 16'h1111);
    send(2'b00, 16'h2222);
    send(2'b00, 16'h3333);
    send(2'b10, 16'h4444);
    send(2'b11, 16'h5555);
    send(2'b10, 16'h0000);
    repeat (3) @(posedge clk);
    #1;
    chk("proto_no_resp", 128'(noc.dbgnoc_out_valid), 128'(0));
    chk("proto_regs_kept", 128'(regs_flat[15:0]), 128'(16'h1234));
    read_req(5'd6, 16'h0002, 16'h1234);
    wait_drain("drain_after_proto");

    // Protected write to reg 1
    write_req(16'h0001, 16'h5555);
    @(posedge clk);
    #1;
    chk("wr_ro_strobe", 128'(reg_wr_strobe), 128'(0));
    read_req(5'd2, 16'h0001, MVER);
    wait_drain("drain_ro");

    // Reset while in RESP_DATA: only the header is delivered
    exp_q.push_back({2'b01, 5'd2, 3'b010, 3'b000, MID});
    send(2'b01, req_hdr(3'b000, 5'd2));
    send(2'b10, 16'h0000);
    @(posedge clk);
    #1;
    noc.dbgnoc_out_ready = 1'b0;
    chk("resp_data_held", 128'(noc.dbgnoc_out_flit), 128'({2'b10, 16'hbeef}));
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    chk("midrst_out_valid", 128'(noc.dbgnoc_out_valid), 128'(0));
    chk("midrst_out_flit", 128'(noc.dbgnoc_out_flit), 128'(0));
    chk("midrst_in_ready", 128'(noc.dbgnoc_in_ready), 128'(0));
    chk("midrst_regs", 128'(regs_flat), 128'(0));
    rst_n = 1'b1;
    noc.dbgnoc_out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("midrst_idle_ready", 128'(noc.dbgnoc_in_ready), 128'(1));
    chk("midrst_queue", 128'(exp_q.size()), 128'(0));
    read_req(5'd2, 16'h0002, 16'h0000);
    wait_drain("drain_final");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
